hex_display_scanner: RTL

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment hex digits, replacing the one-decoder-per-digit scheme with a single shared decoder. Captures a multi-digit hex value, scans it one digit per refresh slot, and adds leading-zero suppression, per-digit blink and tear-free frame-synchronous updates. Sits between datapath result registers and the board's segment and digit-select pins.

---
 rtl/hex_display_scanner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed common-anode hex display driver with one shared decoder,
// leading-zero blanking, per-digit blink and frame-synchronous value updates.
module hex_display_scanner #(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic                  enable_i,
  input  logic                  lz_suppress_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     digit_sel_o,
  output logic                  frame_done_o
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] staging_q, staging_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fdone_q, fdone_d;

  logic                slot_wrap;
  logic                boundary;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_run;
  logic [3:0]          nib;
  logic                lz_bit;
  logic                bm_bit;
  logic                blank;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run;
    end
  end

  always_comb begin
    nib    = 4'h0;
    lz_bit = 1'b0;
    bm_bit = 1'b0;
    sel_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = shadow_q[4*i +: 4];
        lz_bit = lz_mask[i];
        bm_bit = blink_mask_i[i];
        sel_d[i] = !(enable_i && (slot_q != '0));
      end
    end
    blank = (lz_suppress_i && lz_bit) || (phase_q && bm_bit);
    seg_d = (enable_i && !blank) ? glyph(nib) : 7'h7F;
  end

  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    boundary  = enable_i && slot_wrap && (idx_q == IDX_LAST);
    fdone_d   = boundary;

    slot_d = slot_q;
    idx_d  = idx_q;
    if (enable_i) begin
      slot_d = slot_wrap ? '0 : slot_q + SW'(1);
      if (slot_wrap)
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    // Commit uses staging as it stood before this cycle's load
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
    if (load_i) begin
      staging_d = value_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      slot_q    <= '0;
      idx_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      seg_q     <= 7'h7F;
      sel_q     <= '1;
      fdone_q   <= 1'b0;
    end else begin
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fdone_q   <= fdone_d;
    end
  end

  assign seg_o        = seg_q;
  assign digit_sel_o  = sel_q;
  assign frame_done_o = fdone_q;

endmodule
